// File: rtl/hex_tx_pkg.sv
// Shared types and constants for the hex frame sequencer.
// Build option HEX_TX_EOL_EN adds the CR/LF tail states and constants.
package hex_tx_pkg;

`ifdef HEX_TX_EOL_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        CR   = 2'd2,
        LF   = 2'd3
    } state_e;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1
    } state_e;
`endif

    localparam int NIBBLES = 4;
    localparam int IDX_W   = $clog2(NIBBLES);

    localparam logic [7:0] ASCII_DIGIT_BASE = 8'h30;
    localparam logic [7:0] ASCII_ALPHA_BASE = 8'h41;

endpackage

// File: rtl/hex_tx_sequencer_nibble_to_ascii.sv
// Combinational 4-bit to upper-case ASCII hex digit converter.
// Independent of HEX_TX_EOL_EN.
module nibble_to_ascii
    import hex_tx_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [7:0] ascii_o
);

    // Digits 0-9 map onto '0'.., values 10-15 onto 'A'..
    always_comb begin
        if (nibble_i < 4'd10) begin
            ascii_o = ASCII_DIGIT_BASE + {4'h0, nibble_i};
        end else begin
            ascii_o = ASCII_ALPHA_BASE + ({4'h0, nibble_i} - 8'd10);
        end
    end

endmodule

// File: rtl/hex_tx_sequencer.sv
// Snapshots sw and streams it as four ASCII hex bytes over valid/ready.
// With HEX_TX_EOL_EN defined each frame is followed by CR, LF.
module hex_tx_sequencer
    import hex_tx_pkg::*;
#(
    parameter int PERIOD_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] sw,
    input  logic        start,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NIBBLES - 1);
    localparam logic             TIMER_EN   = (PERIOD_CYCLES != 0);
    localparam logic [31:0]      TIMER_LAST = 32'(PERIOD_CYCLES - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [15:0]      shadow_q, shadow_d;
    logic [31:0]      timer_q, timer_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, busy_q, done_q, done_d;
    logic             accept_s, timer_fire_s;
    logic [3:0]       nibble_s;
    logic [7:0]       ascii_s;

    assign accept_s     = tx_valid_q & tx_ready;
    assign timer_fire_s = TIMER_EN & (timer_q == TIMER_LAST);

    // Frame sequencing; the timer only runs while idle and is zero elsewhere.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        timer_d  = 32'd0;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start || timer_fire_s) begin
                    state_d  = SEND;
                    idx_d    = {IDX_W{1'b0}};
                    shadow_d = sw;
                end else if (TIMER_EN) begin
                    timer_d = timer_q + 32'd1;
                end else begin
                    timer_d = 32'd0;
                end
            end
            SEND: begin
                if (accept_s && (idx_q == LAST_IDX)) begin
`ifdef HEX_TX_EOL_EN
                    state_d = CR;
`else
                    state_d = IDLE;
                    done_d  = 1'b1;
`endif
                end else if (accept_s) begin
                    idx_d = idx_q + IDX_W'(1);
                end else begin
                    idx_d = idx_q;
                end
            end
`ifdef HEX_TX_EOL_EN
            CR: begin
                if (accept_s) begin
                    state_d = LF;
                end else begin
                    state_d = CR;
                end
            end
            LF: begin
                if (accept_s) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = LF;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Select the nibble of the byte that will be presented next cycle.
    always_comb begin
        case (idx_d)
            2'd0:    nibble_s = shadow_d[15:12];
            2'd1:    nibble_s = shadow_d[11:8];
            2'd2:    nibble_s = shadow_d[7:4];
            2'd3:    nibble_s = shadow_d[3:0];
            default: nibble_s = shadow_d[15:12];
        endcase
    end

    nibble_to_ascii u_nibble_to_ascii (
        .nibble_i (nibble_s),
        .ascii_o  (ascii_s)
    );

    // Next output byte follows the next state so outputs stay registered.
    always_comb begin
        case (state_d)
            SEND:    tx_data_d = ascii_s;
`ifdef HEX_TX_EOL_EN
            CR:      tx_data_d = ASCII_CR;
            LF:      tx_data_d = ASCII_LF;
`endif
            default: tx_data_d = 8'h00;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= {IDX_W{1'b0}};
            shadow_q   <= 16'h0000;
            timer_q    <= 32'd0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            timer_q    <= timer_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= (state_d != IDLE);
            busy_q     <= (state_d != IDLE);
            done_q     <= done_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_hex_tx_sequencer.sv
// Randomized and directed bench for hex_tx_sequencer against a byte-queue model.
// Expected frame tail follows HEX_TX_EOL_EN the same way as the design build.
module tb_hex_tx_sequencer;

    localparam int PERIOD = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        tx_ready = 1'b0;
    logic [15:0] sw = 16'h0000;
    logic [7:0]  tx_data;
    logic        tx_valid, busy, done;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] exp_q[$];
    logic       exp_done  = 1'b0;
    logic       after_rst = 1'b0;
    int         timer_m   = 0;
    int         idle_run  = 0;
    logic       gap_chk   = 1'b0;
    string      hexs      = "0123456789ABCDEF";

    hex_tx_sequencer #(.PERIOD_CYCLES(PERIOD)) dut (
        .clk      (clk),
        .rst      (rst),
        .sw       (sw),
        .start    (start),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // Model: a frame is the list of bytes still to be sent; busy while the list is non-empty.
    task automatic model_update(input logic r, input logic s, input logic [15:0] v, input logic rdy);
        after_rst = 1'b0;
        if (r) begin
            exp_q.delete();
            exp_done  = 1'b0;
            timer_m   = 0;
            after_rst = 1'b1;
        end else if (exp_q.size() != 0) begin
            exp_done = 1'b0;
            timer_m  = 0;
            if (rdy) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) exp_done = 1'b1;
            end
        end else begin
            exp_done = 1'b0;
            if (s || (timer_m == PERIOD - 1)) begin
                for (int i = 0; i < 4; i++) begin
                    int nib;
                    nib = int'((v >> (12 - 4 * i)) & 16'h000F);
                    exp_q.push_back(hexs.getc(nib));
                end
`ifdef HEX_TX_EOL_EN
                exp_q.push_back(8'h0D);
                exp_q.push_back(8'h0A);
`endif
                timer_m = 0;
            end else begin
                timer_m++;
            end
        end
    endtask

    task automatic step(input logic r, input logic s, input logic [15:0] v, input logic rdy);
        logic ev;
        rst = r; start = s; sw = v; tx_ready = rdy;
        @(posedge clk);
        model_update(r, s, v, rdy);
        #1;
        ev = (exp_q.size() != 0);
        check_eq("tx_valid", {15'd0, tx_valid}, {15'd0, ev});
        check_eq("busy", {15'd0, busy}, {15'd0, ev});
        check_eq("done", {15'd0, done}, {15'd0, exp_done});
        if (ev || after_rst) check_eq("tx_data", {8'd0, tx_data}, {8'd0, (ev ? exp_q[0] : 8'h00)});
        if (r) begin
            idle_run = 1;
        end else if (busy === 1'b0) begin
            idle_run++;
        end else begin
            if (gap_chk && idle_run != 0) check_eq("timer_gap", 16'(idle_run), 16'(PERIOD));
            idle_run = 0;
        end
    endtask

    initial begin
        logic [3:0] pat;
        logic       s_en;
        pat = 4'b1001;

        // Periodic trigger only: two frames after reset, 100 idle cycles each
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        gap_chk = 1'b1;
        for (int k = 0; k < 240; k++) step(1'b0, 1'b0, 16'h5A3C, 1'b1);
        gap_chk = 1'b0;

        // 1A2F with back-to-back accepts
        step(1'b1, 1'b0, 16'h0000, 1'b1);
        step(1'b0, 1'b1, 16'h1A2F, 1'b1);
        for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 16'h0000, 1'b1);

        // Snapshot 0000, then FFFF and extra start pulses during the frame
        step(1'b0, 1'b1, 16'h0000, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 16'hFFFF, 1'b1);
        for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 16'hFFFF, 1'b1);

        // BEEF with ready pattern 1-0-0-1 stalls
        step(1'b0, 1'b1, 16'hBEEF, 1'b0);
        for (int k = 0; k < 24; k++) step(1'b0, 1'b0, 16'h1234, pat[3 - (k % 4)]);

        // Reset after the second accepted byte, then a full new frame
        step(1'b0, 1'b1, 16'h9C05, 1'b1);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        step(1'b1, 1'b0, 16'h0000, 1'b1);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        step(1'b0, 1'b1, 16'h9C05, 1'b1);
        for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 16'h0000, 1'b1);

        // F00D frame
        step(1'b0, 1'b1, 16'hF00D, 1'b1);
        for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 16'h0000, 1'b1);

        // Random traffic; start is masked in alternate phases so the timer fires too
        for (int k = 0; k < 3000; k++) begin
            s_en = ((k / 400) % 2) == 0;
            step(($urandom_range(0, 299) == 0),
                 s_en && ($urandom_range(0, 7) == 0),
                 16'($urandom),
                 ($urandom_range(0, 3) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hex_tx_sequencer.md
# hex_tx_sequencer

Frame sequencer that snapshots the 16-bit switch value, converts it nibble by nibble to upper-case ASCII hex, and streams the characters to the board UART transmitter over a valid/ready byte interface. It sits between the switch/debounce logic and the UART TX, replacing free-running per-clock conversion with framed, back-pressured transmission. Frames are triggered by a start pulse or by an optional periodic timer.

## Interface
- PERIOD_CYCLES, 0, idle cycles between automatic frames; 0 disables the periodic trigger
- clk  in  1  system clock, 100 MHz
- rst  in  1  reset; one clock, synchronous, active-high
- sw  in  16  value to send; sampled only at frame start
- start  in  1  frame request pulse; sampled in IDLE only
- tx_data  out  8  ASCII byte to UART TX
- tx_valid  out  1  tx_data is valid
- tx_ready  in  1  UART TX accepts the byte this cycle
- busy  out  1  frame in progress (state != IDLE)
- done  out  1  one-cycle pulse after the last byte of a frame is accepted

## Operation
- States: IDLE, SEND, CR, LF.
- IDLE: a trigger is `start`=1 or periodic timer expiry. On a trigger, capture `sw` into a shadow register, clear the nibble index to 0, and go to SEND.
- SEND:
  - tx_data = ASCII of shadow nibble [15-4i : 12-4i], MSB nibble first.
  - Nibble mapping: 0–9 -> 0x30–0x39; 10–15 -> 0x41–0x46. No lower case.
  - On accept (tx_valid & tx_ready) with i<3: i increments.
  - On accept with i=3: go to CR, or go to IDLE if the EOL feature is compiled out.
- CR: tx_data=0x0D; on accept, go to LF.
- LF: tx_data=0x0A; on accept, go to IDLE.
- `start` is ignored while busy; requests are not queued.
- Changes on `sw` during a frame have no effect on that frame.
- Periodic timer:
  - Counts only in IDLE and is cleared on entry to IDLE.
  - Fires when it reaches PERIOD_CYCLES-1.
  - `start` and timer expiry in the same cycle produce one frame.

## Timing
- Reset values: tx_valid=0, tx_data=8'h00, busy=0, done=0, state=IDLE, index=0, timer=0, shadow=16'h0000.
- Trigger sampled at edge N; tx_valid=1 and busy=1 from cycle N+1.
- All outputs are registered.
- tx_valid stays high and tx_data stays stable until accepted.
- The next byte is presented the cycle after an accept, so with tx_ready held at 1 there is one byte per cycle and no bubbles.
- Frame length: 6 bytes (4 without EOL). Minimum frame is 6 cycles from first tx_valid.
- done pulses in the cycle busy returns to 0, i.e. one cycle after the final accept. A new trigger is accepted in that same cycle.
- rst asserted mid-frame: the frame is aborted, and the next cycle shows all outputs at their reset values. No partial completion and no done pulse.
- tx_ready while tx_valid=0 is ignored.

## Configuration
- HEX_TX_EOL_EN defined: each frame ends with CR (0x0D), LF (0x0A); all four states are used.
- HEX_TX_EOL_EN undefined: CR/LF states and constants are not compiled. The frame is exactly four hex bytes, and SEND with i=3 returns directly to IDLE on accept.

## Structure
- Package hex_tx_pkg:
  - state enum (IDLE, SEND, CR, LF)
  - ASCII_CR=8'h0D, ASCII_LF=8'h0A
  - NIBBLES=4
  - ASCII_DIGIT_BASE=8'h30, ASCII_ALPHA_BASE=8'h41
- Sub-module nibble_to_ascii: combinational 4-bit -> 8-bit converter. It is instanced once, driven by the nibble mux output, and its result is registered into tx_data.

## Test plan
- EOL on, sw=16'h1A2F, start pulse, tx_ready=1 -> bytes 0x31,0x41,0x32,0x46,0x0D,0x0A on 6 consecutive cycles; done one cycle after 0x0A; busy=1 for exactly 6 cycles.
- sw=16'h0000, start, then sw=16'hFFFF from the second byte on -> all four hex bytes are 0x30; start pulses during the frame produce no second frame.
- sw=16'hBEEF, tx_ready toggling 1-0-0-1 -> tx_data holds each of 0x42,0x45,0x45,0x46 stable while stalled; no byte is dropped or duplicated.
- PERIOD_CYCLES=100, no start, tx_ready=1 -> first frame begins after 100 idle cycles following reset; frames then repeat with exactly 100 IDLE cycles between done and the next tx_valid.
- rst held for one cycle after the 2nd byte of sw=16'h9C05 is accepted -> tx_valid=0 and busy=0 next cycle, no done; a new start then sends a full frame from 0x39.
- HEX_TX_EOL_EN undefined, sw=16'hF00D -> exactly 0x46,0x30,0x30,0x44 then done; no 0x0D/0x0A ever appears.
